// File: rtl/router_output_arbiter.sv
// Per-output round-robin arbiter for the router crossbar: each output grants one
// requesting input and holds it until that input's done pulse or a hold timeout.
module router_output_arbiter #(
    parameter int NPORTS   = 16,
    parameter int PW       = 4,
    parameter int MAX_HOLD = 1024
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NPORTS-1:0]    req,
    input  logic [NPORTS*PW-1:0] req_dest,
    input  logic [NPORTS-1:0]    done,
    output logic [NPORTS-1:0]    in_grant,
    output logic [NPORTS*PW-1:0] out_sel,
    output logic [NPORTS-1:0]    out_active,
    output logic [NPORTS-1:0]    busy_n,
    output logic [NPORTS-1:0]    timeout
);

    localparam int CW = $clog2(MAX_HOLD);

    typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

    logic [NPORTS-1:0]    owned_vec;
    logic [NPORTS*PW-1:0] sel_flat;

    // An input is granted when any owned output selects it.
    always_comb begin
        in_grant = '0;
        for (int o = 0; o < NPORTS; o++) begin
            if (owned_vec[o]) in_grant[sel_flat[o*PW +: PW]] = 1'b1;
        end
    end

    for (genvar o = 0; o < NPORTS; o++) begin : g_out
        state_t            state_q;
        state_t            state_d;
        logic [PW-1:0]     sel_q;
        logic [PW-1:0]     ptr_q;
        logic [CW-1:0]     cnt_q;
        logic              tout_q;
        logic [NPORTS-1:0] cand;
        logic              found;
        logic [PW-1:0]     pick;
        logic [PW-1:0]     idx;
        logic              expire;
        logic              release_now;
        logic              owned;

        always_comb begin
            cand = '0;
            for (int i = 0; i < NPORTS; i++) begin
                cand[i] = req[i] && (req_dest[i*PW +: PW] == PW'(o)) && !in_grant[i];
            end
        end

        // Scan from the pointer; PW-bit arithmetic wraps modulo NPORTS.
        always_comb begin
            found = 1'b0;
            pick  = ptr_q;
            idx   = ptr_q;
            for (int k = 0; k < NPORTS; k++) begin
                idx = ptr_q + PW'(k);
                if (!found && cand[idx]) begin
                    found = 1'b1;
                    pick  = idx;
                end
            end
        end

        assign expire      = (cnt_q == CW'(MAX_HOLD - 1));
        assign release_now = done[sel_q] || expire;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) state_q <= IDLE;
            else          state_q <= state_d;
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                IDLE:    if (found)       state_d = OWNED;
                OWNED:   if (release_now) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        always_comb begin
            owned = (state_q == OWNED);
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                sel_q  <= '0;
                ptr_q  <= '0;
                cnt_q  <= '0;
                tout_q <= 1'b0;
            end else begin
                tout_q <= owned && expire;
                if (!owned && found) begin
                    sel_q <= pick;
                    ptr_q <= pick + PW'(1);
                    cnt_q <= '0;
                end else if (owned) begin
                    cnt_q <= release_now ? '0 : cnt_q + CW'(1);
                end
            end
        end

        assign owned_vec[o]           = owned;
        assign sel_flat[o*PW +: PW]   = sel_q;
        assign out_sel[o*PW +: PW]    = sel_q;
        assign out_active[o]          = owned;
        assign busy_n[o]              = ~owned;
        assign timeout[o]             = tout_q;
    end

endmodule

// File: tb/tb_router_output_arbiter.sv
// Directed bench for router_output_arbiter: a default instance plus a short-hold
// instance (MAX_HOLD=8) for the forced-release cases.
module tb_router_output_arbiter;

    logic        clock;
    logic        reset_n;
    logic [15:0] req;
    logic [63:0] req_dest;
    logic [15:0] done;

    logic [15:0] in_grant,  out_active,  busy_n,  timeout;
    logic [63:0] out_sel;
    logic [15:0] in_grant8, out_active8, busy_n8, timeout8;
    logic [63:0] out_sel8;

    int compared = 0;
    int mismatched = 0;

    router_output_arbiter #(.NPORTS(16), .PW(4), .MAX_HOLD(1024)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .req_dest(req_dest), .done(done),
        .in_grant(in_grant), .out_sel(out_sel), .out_active(out_active),
        .busy_n(busy_n), .timeout(timeout)
    );

    router_output_arbiter #(.NPORTS(16), .PW(4), .MAX_HOLD(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .req(req), .req_dest(req_dest), .done(done),
        .in_grant(in_grant8), .out_sel(out_sel8), .out_active(out_active8),
        .busy_n(busy_n8), .timeout(timeout8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] dest);
        req[i] = 1'b1;
        req_dest[i*4 +: 4] = dest;
    endtask

    function automatic logic [3:0] sel_of(input logic [63:0] sel, input int o);
        return sel[o*4 +: 4];
    endfunction

    // Pulse done for the current owner of output 2, verify the idle cycle, then the next grant.
    task automatic rr_next(input int owner, input int next_owner, input string tag);
        done = 16'h0;
        done[owner] = 1'b1;
        step();
        done = 16'h0;
        check({tag, "_idle_active"}, {63'd0, out_active[2]}, 64'd0);
        check({tag, "_idle_grant"}, in_grant, 64'h0);
        step();
        check({tag, "_sel"}, sel_of(out_sel, 2), next_owner);
        check({tag, "_grant"}, in_grant, 64'd1 << next_owner);
    endtask

    initial begin
        reset_n  = 1'b0;
        req      = 16'h0;
        req_dest = 64'h0;
        done     = 16'h0;

        // Reset values hold before any clock edge.
        #2;
        check("rst_busy_n", busy_n, 64'hFFFF);
        check("rst_grant", in_grant, 64'h0);
        check("rst_sel", out_sel, 64'h0);
        step();
        reset_n = 1'b1;
        step();
        check("idle_busy_n", busy_n, 64'hFFFF);
        check("idle_grant", in_grant, 64'h0);
        check("idle_active", out_active, 64'h0);
        check("idle_timeout", timeout, 64'h0);

        // Single grant, held across a dropped req, released by done.
        set_req(3, 4'd5);
        step();
        check("single_grant", in_grant, 64'h0008);
        check("single_sel", sel_of(out_sel, 5), 64'd3);
        check("single_busy_n", busy_n, 64'hFFDF);
        req = 16'h0;
        for (int c = 0; c < 9; c++) step();
        check("single_held", in_grant, 64'h0008);
        done[3] = 1'b1;
        step();
        done = 16'h0;
        check("single_rel_busy_n", busy_n, 64'hFFFF);
        check("single_rel_grant", in_grant, 64'h0);
        check("single_sel_hold", sel_of(out_sel, 5), 64'd3);
        check("single_no_timeout", timeout, 64'h0);

        // Round robin on output 2 among inputs 0, 4, 9 with continuous requests.
        set_req(0, 4'd2);
        set_req(4, 4'd2);
        set_req(9, 4'd2);
        step();
        check("rr0_sel", sel_of(out_sel, 2), 64'd0);
        check("rr0_grant", in_grant, 64'h0001);
        rr_next(0, 4, "rr1");
        rr_next(4, 9, "rr2");
        rr_next(9, 0, "rr3");
        req = 16'h0;
        done[0] = 1'b1;
        step();
        done = 16'h0;
        check("rr_end_busy_n", busy_n, 64'hFFFF);

        // All 16 outputs granted on the same edge.
        for (int i = 0; i < 16; i++) set_req(i, 4'(15 - i));
        step();
        check("par_grant", in_grant, 64'hFFFF);
        check("par_busy_n", busy_n, 64'h0);
        check("par_active", out_active, 64'hFFFF);
        for (int o = 0; o < 16; o++) check($sformatf("par_sel%0d", o), sel_of(out_sel, o), 15 - o);
        req  = 16'h0;
        done = 16'hFFFF;
        step();
        done = 16'h0;
        check("par_rel_busy_n", busy_n, 64'hFFFF);

        // Forced release on the MAX_HOLD=8 instance.
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        set_req(7, 4'd1);
        step();
        check("to_grant", in_grant8, 64'h0080);
        req = 16'h0;
        set_req(2, 4'd1);
        for (int c = 0; c < 7; c++) step();
        check("to_pre_timeout", timeout8, 64'h0);
        check("to_pre_busy_n", {63'd0, busy_n8[1]}, 64'd0);
        step();
        check("to_pulse", timeout8, 64'h0002);
        check("to_rel_busy_n", {63'd0, busy_n8[1]}, 64'd1);
        check("to_rel_grant", in_grant8, 64'h0);
        step();
        check("to_pulse_end", timeout8, 64'h0);
        check("to_next_grant", in_grant8, 64'h0004);
        check("to_next_sel", sel_of(out_sel8, 1), 64'd2);
        req = 16'h0;

        // done coinciding with expiry: one release, timeout still pulsed.
        for (int c = 0; c < 7; c++) step();
        check("tod_still_owned", in_grant8, 64'h0004);
        done[2] = 1'b1;
        step();
        done = 16'h0;
        check("tod_pulse", timeout8, 64'h0002);
        check("tod_rel_grant", in_grant8, 64'h0);
        step();
        check("tod_pulse_end", timeout8, 64'h0);

        // Asynchronous reset mid-frame clears ownership without a clock edge.
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        set_req(3, 4'd5);
        set_req(7, 4'd1);
        step();
        check("mr_owned", busy_n, 64'hFFDD);
        req = 16'h0;
        #3;
        reset_n = 1'b0;
        #1;
        check("mr_busy_n", busy_n, 64'hFFFF);
        check("mr_grant", in_grant, 64'h0);
        check("mr_active", out_active, 64'h0);
        check("mr_sel", out_sel, 64'h0);
        set_req(1, 4'd5);
        set_req(8, 4'd5);
        #2;
        reset_n = 1'b1;
        step();
        check("mr_ptr_sel", sel_of(out_sel, 5), 64'd1);
        check("mr_ptr_grant", in_grant, 64'h0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/router_output_arbiter.md
Name: router_output_arbiter

Overview:
- Per-output-port round-robin arbiter for the 16x16 router crossbar.
- Each input port, once it has decoded its 4-bit destination address from the frame header, raises a request. The arbiter grants exclusive ownership of the destination output port to exactly one input and holds the grant until that input signals end of frame.
- Drives the crossbar select lines and the per-output busy_n indication seen at the router boundary.

Parameters:
- NPORTS, 16, number of input ports and of output ports (power of two, 2..16).
- PW, 4, port index width, equal to log2(NPORTS).
- MAX_HOLD, 1024, maximum grant duration in cycles before forced release (>=2).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  NPORTS  req[i]=1: input i requests output req_dest[i].
- req_dest  input  NPORTS*PW  destination of input i in bits [i*PW +: PW].
- done  input  NPORTS  single-cycle pulse: input i finished its frame (frame_n rose).
- in_grant  output  NPORTS  in_grant[i]=1: input i currently owns an output.
- out_sel  output  NPORTS*PW  crossbar select; owning input index of output o in bits [o*PW +: PW].
- out_active  output  NPORTS  out_active[o]=1: out_sel for output o is valid.
- busy_n  output  NPORTS  busy_n[o]=0 while output o is owned; equals ~out_active.
- timeout  output  NPORTS  one-cycle pulse on output o when its grant is force-released.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - in_grant=0, out_sel=0, out_active=0, busy_n=all 1s, timeout=0.
  - All round-robin pointers=0, all hold counters=0.
- Per output o, a two-state FSM: IDLE and OWNED.
- IDLE:
  - Candidate set = {i : req[i]=1, req_dest[i]==o, in_grant[i]=0}.
  - If the set is non-empty, choose the first candidate scanning i = ptr[o], ptr[o]+1, … modulo NPORTS.
  - Next edge: OWNED, out_sel[o]=i, out_active[o]=1, busy_n[o]=0, in_grant[i]=1, ptr[o]=(i+1) mod NPORTS, hold counter=0.
  - Latency from req to grant is 1 cycle.
- OWNED:
  - Hold counter increments every cycle.
  - If done[owner]=1: next edge returns to IDLE; out_active[o]=0, busy_n[o]=1, in_grant[owner]=0.
  - The output cannot be re-granted in the same edge as its release. The earliest new grant is 1 cycle after release, giving a minimum of 1 idle cycle between frames.
  - If the hold counter reaches MAX_HOLD-1 without done: release exactly as for done, and pulse timeout[o] for 1 cycle.
  - done and timeout in the same cycle: a single release, and timeout is still pulsed.
- While in_grant[i]=1:
  - req[i] and req_dest[i] are ignored; the grant is not revoked by req falling.
  - Only done[i] or a timeout ends the grant.
- done[i] while input i owns nothing is ignored.
- A requester that is not yet granted samples req_dest every cycle. Changing the destination before grant simply moves its request.
- Simultaneous events across outputs are independent: up to NPORTS grants and releases may occur on the same edge.
- Each input holds at most one grant, since its request targets exactly one output.
- ptr[o] advances only on a grant, never on release or timeout.
- out_sel[o] holds its last value while out_active[o]=0.

Test Plan:
- Reset then idle: after reset_n rises with no req → busy_n=16'hFFFF, in_grant=0, out_active=0, timeout=0.
- Single grant: req[3]=1, dest[3]=5 at cycle 0 → at cycle 1 in_grant[3]=1, out_sel[5]=3, busy_n[5]=0. Pulse done[3] at cycle 10 → at cycle 11 busy_n[5]=1 and in_grant[3]=0.
- Round-robin fairness: inputs 0, 4 and 9 all request output 2 and continuously re-request after each done → grant order 0, 4, 9, 0. After release, output 2 stays idle exactly 1 cycle before the next grant.
- Parallel outputs: input i requests output 15-i for all 16 inputs in the same cycle → next cycle in_grant=16'hFFFF, out_sel[o]=15-o for every o, busy_n=0.
- Timeout with MAX_HOLD=8: input 7 granted output 1 and never sends done → timeout[1] pulses 8 cycles after the grant, busy_n[1] returns to 1 and in_grant[7] clears. A competing req[2] to output 1 is granted the following cycle.
- Mid-frame reset: with outputs 5 and 1 owned, assert reset_n=0 asynchronously between clock edges → outputs return to reset values immediately, without waiting for a clock edge. After release, the first grant to output 5 goes to the lowest-index requester, since ptr was reset to 0.
